display_scan_controller: RTL and testbench

- Time-multiplexes one shared 3-bit column decoder across NDIG common-anode digits of the 7-segment display.
- Holds a double-buffered 3-bit code per digit. Drives the shared decoder input (CODE) and one active-low digit strobe (DIG_N) per digit, with a blanking gap between digits to stop ghosting.
- Host writes go to shadow registers. They are committed to the display only at frame boundaries, so a frame never tears.

---
 rtl/display_scan_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_display_scan_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexes one shared 3-bit column decoder across NDIG = 2**ADDR_W
//   common-anode 7-segment digits. Each frame visits every digit in turn:
//   BLANK_CYC dark cycles, then DWELL cycles with that digit's code on CODE
//   and its active-low strobe pulled low. Host writes land in a shadow bank
//   and are copied to the displayed bank only at the end of a frame, so a
//   frame never shows a mix of old and new codes.
//
//   Optional feature macro: DISPLAY_SCAN_BLINK_EN
//     Adds the BLINK_MASK input and the BLINK_FRAMES parameter. A blink phase
//     toggles every BLINK_FRAMES frames; while it is 1, masked digits stay dark
//     for their lit slot (slot timing unchanged).
//
// Ports
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-high reset
//   ENABLE      in   scan enable; low forces the display dark
//   WR          in   write strobe
//   WR_ADDR     in   digit index of the write
//   WR_DATA     in   3-bit column code of the write (bit2 = A)
//   BLINK_MASK  in   per-digit blink enable (feature builds only)
//   CODE        out  code presented to the shared decoder
//   CODE_VALID  out  high while a digit is lit
//   DIG_N       out  active-low digit strobes, at most one low
//   DIG_IDX     out  index of the current scan slot
//   PENDING     out  shadow bank holds uncommitted writes
//   FRAME_DONE  out  one-cycle pulse on each frame commit point
module display_scan_controller #(
  parameter int ADDR_W       = 2,
  parameter int DWELL        = 1000,
  parameter int BLANK_CYC    = 16,
  parameter int CNT_W        = 16
`ifdef DISPLAY_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic                     WR,
  input  logic [ADDR_W-1:0]        WR_ADDR,
  input  logic [2:0]               WR_DATA,
`ifdef DISPLAY_SCAN_BLINK_EN
  input  logic [(1<<ADDR_W)-1:0]   BLINK_MASK,
`endif
  output logic [2:0]               CODE,
  output logic                     CODE_VALID,
  output logic [(1<<ADDR_W)-1:0]   DIG_N,
  output logic [ADDR_W-1:0]        DIG_IDX,
  output logic                     PENDING,
  output logic                     FRAME_DONE
);

  localparam int NDIG = 1 << ADDR_W;

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        shadow_q [NDIG];
  logic [2:0]        shadow_d [NDIG];
  logic [2:0]        active_q [NDIG];
  logic [2:0]        active_d [NDIG];
  logic [2:0]        code_q, code_d;
  logic              code_valid_q, code_valid_d;
  logic [NDIG-1:0]   dig_n_q, dig_n_d;
  logic              pending_q, pending_d;
  logic              frame_done_q, frame_done_d;
  logic              suppress;

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           phase_q, phase_d;
  // Phase and mask only change away from the SHOW entry edge, so the
  // registered phase is the right one to sample here.
  assign suppress = phase_q & BLINK_MASK[idx_q];
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    dig_n_d      = dig_n_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_OFF: begin
        idx_d        = '0;
        cnt_d        = '0;
        dig_n_d      = '1;
        code_valid_d = 1'b0;
        if (ENABLE) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (!ENABLE) begin
          state_d      = S_OFF;
          idx_d        = '0;
          cnt_d        = '0;
          dig_n_d      = '1;
          code_valid_d = 1'b0;
        end else if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
          state_d = S_SHOW;
          cnt_d   = '0;
          code_d  = active_q[idx_q];
          if (!suppress) begin
            dig_n_d      = ~(NDIG'(1) << idx_q);
            code_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHOW: begin
        if (!ENABLE) begin
          state_d      = S_OFF;
          idx_d        = '0;
          cnt_d        = '0;
          dig_n_d      = '1;
          code_valid_d = 1'b0;
        end else if (cnt_q == CNT_W'(DWELL - 1)) begin
          state_d      = S_BLANK;
          cnt_d        = '0;
          dig_n_d      = '1;
          code_valid_d = 1'b0;
          idx_d        = idx_q + ADDR_W'(1);  // NDIG is a power of two: wraps
          if (idx_q == ADDR_W'(NDIG - 1)) begin
            frame_done_d = 1'b1;
            if (pending_q) begin
              active_d  = shadow_q;  // pre-write shadow; a same-edge write stays pending
              pending_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_OFF;
    endcase

    // A write after the commit overrides the commit's PENDING clear.
    if (WR) begin
      shadow_d[WR_ADDR] = WR_DATA;
      pending_d         = 1'b1;
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (state_d == S_OFF) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (frame_done_d) begin
      if (bcnt_q == BCW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < NDIG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      code_q       <= '0;
      code_valid_q <= 1'b0;
      dig_n_q      <= '1;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      dig_n_q      <= dig_n_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign CODE       = code_q;
  assign CODE_VALID = code_valid_q;
  assign DIG_N      = dig_n_q;
  assign DIG_IDX    = idx_q;
  assign PENDING    = pending_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Testbench for display_scan_controller: random and directed stimulus,
// expected outputs from a frame-position reference model, pushed into a
// queue and compared by an independent monitor on the falling clock edge.
module tb_display_scan_controller;

  localparam int AW   = 2;
  localparam int ND   = 4;
  localparam int DW   = 4;
  localparam int BC   = 2;
  localparam int SLOT = BC + DW;
  localparam int P    = ND * SLOT;
  localparam int BF   = 2;

  logic       CLK = 1'b0;
  logic       RST, ENABLE, WR;
  logic [1:0] WR_ADDR;
  logic [2:0] WR_DATA;
  logic [3:0] BLINK_MASK;
  logic [2:0] CODE;
  logic       CODE_VALID;
  logic [3:0] DIG_N;
  logic [1:0] DIG_IDX;
  logic       PENDING, FRAME_DONE;

  always #5 CLK = ~CLK;

  display_scan_controller #(
    .ADDR_W(AW), .DWELL(DW), .BLANK_CYC(BC), .CNT_W(16)
`ifdef DISPLAY_SCAN_BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .WR(WR),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
`ifdef DISPLAY_SCAN_BLINK_EN
    .BLINK_MASK(BLINK_MASK),
`endif
    .CODE(CODE), .CODE_VALID(CODE_VALID), .DIG_N(DIG_N),
    .DIG_IDX(DIG_IDX), .PENDING(PENDING), .FRAME_DONE(FRAME_DONE)
  );

  typedef struct {
    logic [2:0] code;
    logic       valid;
    logic [3:0] dig_n;
    logic [1:0] idx;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: s = cycles since the scan was (re)started in BLANK.
  bit         m_on;
  int         m_s;
  logic [2:0] m_sh  [ND];
  logic [2:0] m_act [ND];
  bit         m_pend, m_fd, m_phase;
  int         m_frames;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_on = 0; m_s = 0; m_pend = 0; m_fd = 0; m_phase = 0; m_frames = 0;
    for (int i = 0; i < ND; i++) begin m_sh[i] = 3'd0; m_act[i] = 3'd0; end
  endfunction

  function automatic void model_edge(input bit en, input bit wr, input logic [1:0] a, input logic [2:0] d);
    m_fd = 0;
    if (RST) begin model_reset(); return; end
    if (!m_on) begin
      if (en) begin m_on = 1; m_s = 0; end
    end else if (!en) begin
      m_on = 0; m_s = 0;
    end else begin
      m_s++;
      if (m_s % P == 0) begin
        m_fd = 1;
        if (m_pend) begin m_act = m_sh; m_pend = 0; end
        m_frames++;
        if (m_frames == BF) begin m_frames = 0; m_phase = !m_phase; end
      end
    end
    if (!m_on) begin m_frames = 0; m_phase = 0; end
    if (wr) begin m_sh[a] = d; m_pend = 1; end
  endfunction

  function automatic bit model_lit(output int slot);
    int pos;
    pos  = m_s % P;
    slot = pos / SLOT;
    return m_on && ((pos % SLOT) >= BC);
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    int   slot;
    bit   lit;
    logic [3:0] one = 4'b0001;
    e.pend = m_pend;
    e.fd   = m_fd;
    e.code = 3'd0;
    if (!m_on) begin
      e.valid = 0; e.dig_n = 4'hF; e.idx = 2'd0;
    end else begin
      lit = model_lit(slot);
`ifdef DISPLAY_SCAN_BLINK_EN
      if (m_phase && BLINK_MASK[slot]) lit = 0;
`endif
      e.idx   = 2'(slot);
      e.valid = lit;
      e.dig_n = lit ? ~(one << slot) : 4'hF;
      e.code  = m_act[slot];
    end
    return e;
  endfunction

  task automatic step(input bit en, input bit wr, input logic [1:0] a, input logic [2:0] d);
    ENABLE = en; WR = wr; WR_ADDR = a; WR_DATA = d;
    model_edge(en, wr, a, d);
    q.push_back(model_expect());
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'd0, 3'd0);
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("dig_n", 32'(DIG_N), 32'(e.dig_n));
      check("code_valid", 32'(CODE_VALID), 32'(e.valid));
      check("dig_idx", 32'(DIG_IDX), 32'(e.idx));
      check("pending", 32'(PENDING), 32'(e.pend));
      check("frame_done", 32'(FRAME_DONE), 32'(e.fd));
      if (e.valid) check("code", 32'(CODE), 32'(e.code));
    end
  end

  task automatic bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not reached within bound", nm);
  endtask

  initial begin
    int  slot;
    bit  found;
    RST = 1; ENABLE = 0; WR = 0; WR_ADDR = 0; WR_DATA = 0; BLINK_MASK = 4'b0001;
    model_reset();
    @(negedge CLK); #1;
    step(0, 0, 2'd0, 3'd0);
    step(0, 0, 2'd0, 3'd0);
    RST = 0;
    step(0, 0, 2'd0, 3'd0);

    // Free-running scan: blank/show pattern and FRAME_DONE period.
    idle(3 * P);

    // Mid-frame write, committed at the next frame boundary.
    idle(5);
    step(1, 1, 2'd2, 3'b101);
    idle(2 * P);

    // Write landing exactly on the commit edge stays pending.
    step(1, 1, 2'd0, 3'b110);
    found = 0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      if ((m_s + 1) % P == 0) found = 1;
      else step(1, 0, 2'd0, 3'd0);
    end
    if (!found) bound_fail("commit_edge_search");
    step(1, 1, 2'd1, 3'b011);
    idle(2 * P + 3);

    // Drop ENABLE while digit 1 is lit, then re-enable.
    found = 0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      if (model_lit(slot) && slot == 1) found = 1;
      else step(1, 0, 2'd0, 3'd0);
    end
    if (!found) bound_fail("digit1_show_search");
    step(0, 0, 2'd0, 3'd0);
    step(0, 1, 2'd3, 3'b111);
    step(0, 0, 2'd0, 3'd0);
    idle(P + 4);

    // Randomized traffic with occasional single-cycle enable drops.
    for (int i = 0; i < 1500; i++)
      step(($urandom % 150) != 0, ($urandom % 4) == 0, 2'($urandom), 3'($urandom));

    // Asynchronous reset mid-SHOW after writes.
    step(1, 1, 2'd3, 3'b100);
    step(1, 1, 2'd1, 3'b010);
    found = 0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      if (model_lit(slot) && slot == 2) found = 1;
      else step(1, 0, 2'd0, 3'd0);
    end
    if (!found) bound_fail("reset_show_search");
    RST = 1;
    #1;
    check("rst_async_dig_n", 32'(DIG_N), 32'hF);
    check("rst_async_valid", 32'(CODE_VALID), 32'h0);
    check("rst_async_pending", 32'(PENDING), 32'h0);
    check("rst_async_idx", 32'(DIG_IDX), 32'h0);
    model_reset();
    step(1, 0, 2'd0, 3'd0);
    RST = 0;
    idle(2 * P);

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
